keccak_share_sequencer: RTL and testbench
=========================================

// Module: keccak_share_sequencer
// PURPOSE
//  Host-side sequencer wrapped around the Keccak round controller and masked datapath.
//  Streams SHARES x 25 lanes of W-bit input into the datapath state register via a valid/ready port.
//  Releases the round controller, waits for its Ready, then streams the permuted state out in the same order.
//  Stores no state bits itself: drives load enables, lane/share selects and the controller's active-high reset.
// PARAMETERS
//  W       8   lane width in bits; matches controller/datapath W
//  SHARES  2   number of Boolean shares (>=2); SW = max(1,$clog2(SHARES))
// PORTS
//  Clock       in   1   clock; all state updates on rising edge
//  Reset       in   1   reset, synchronous, active-low
//  InValid     in   1   host input beat valid
//  InReady     out  1   sequencer accepts input beat
//  InData      in   W   input lane word (one share of one lane)
//  OutValid    out  1   output beat valid
//  OutReady    in   1   host accepts output beat
//  OutData     out  W   output lane word, = StateDataI
//  LoadEn      out  1   datapath writes StateDataO into lane LaneSel of share ShareSel
//  StateDataO  out  W   = InData (pass-through to datapath load mux)
//  StateDataI  in   W   datapath read-mux output for LaneSel/ShareSel
//  LaneSel     out  5   lane index 0..24 (x+5y)
//  ShareSel    out  SW  share index 0..SHARES-1
//  CoreReset   out  1   active-high reset to round controller
//  CoreReady   in   1   round controller Ready (permutation finished)
//  Busy        out  1   high in RUN and UNLOAD
// BEHAVIOUR
//  States: LOAD -> RUN -> UNLOAD -> LOAD. Registered: state, LaneCnt[4:0], ShareCnt[SW-1:0].
//  Reset==0 at an edge: state<=LOAD, LaneCnt<=0, ShareCnt<=0.
//  While Reset==0: InReady=0, OutValid=0, LoadEn=0, CoreReset=1, Busy=0 (combinational gating).
//  LaneSel=LaneCnt, ShareSel=ShareCnt in all states.
//  LOAD: InReady=1, CoreReset=1. Beat = InValid&InReady; on beat LoadEn=1 the same cycle.
//   On beat LaneCnt++; at 24 it wraps to 0 and ShareCnt++.
//   Last beat (lane 24, share SHARES-1): both counters -> 0, next state RUN.
//  RUN: CoreReset=0, InReady=0. CoreReady==1 -> UNLOAD next cycle.
//   The controller needs >=1 cycle with reset low before Ready, so CoreReady is ignored outside RUN.
//  UNLOAD: CoreReset=0 (controller parks in FINISH; state frozen), OutValid=1.
//   Beat = OutValid&OutReady advances counters as in LOAD. After the last beat: counters -> 0, next state LOAD.
//   From then CoreReset=1, which re-arms the controller.
//  OutReady low: counters hold, OutData/LaneSel stable (AXI-style: no valid drop once raised).
//  InValid in RUN/UNLOAD ignored, no LoadEn. OutReady outside UNLOAD ignored.
//  Latency: first input beat to first OutValid = SHARES*25 beats + 1 + controller run time + 1 cycle.
//  Reset mid-operation: aborts at next edge, returns to LOAD with counters 0. Partially loaded state is not cleared.
//  Illegal state encoding: next state LOAD.
// STRUCTURE
//  keccak_pkg: LANES=25, SEQ_LOAD/SEQ_RUN/SEQ_UNLOAD one-hot encodings, function share_width(SHARES).
//  Sub-module keccak_beat_counter (#SHARES): inc, clr -> LaneCnt, ShareCnt, Last.
//   Wrap logic lives here; shared by LOAD and UNLOAD.
//  Top contains the FSM and output decode only.
// TESTING
//  1 Reset=0 for 3 cycles, then 1 -> InReady=1, CoreReset=1, OutValid=0, LaneSel=0, ShareSel=0.
//  2 SHARES=2, 50 beats with InValid=1 -> LoadEn for 50 cycles; Lane 0..24 twice; ShareSel 0 then 1.
//    Next cycle: Busy=1, CoreReset=0.
//  3 InValid toggled 1/0 during load -> exactly 50 LoadEn pulses; counters hold on idle cycles.
//  4 CoreReady pulse 1 cycle in RUN -> OutValid next cycle, OutData=StateDataI.
//    OutReady held 0 for 5 cycles -> LaneSel stays 0.
//  5 Full unload with OutReady=1 -> 50 beats, then InReady=1, CoreReset=1, Busy=0.
//  6 Reset=0 after 30 load beats, or in UNLOAD at beat 10 -> next cycle LOAD, counters 0, no stray LoadEn.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak share sequencer slice.
// Sequencer states are one-hot so that any corrupted encoding is easy to detect.
package keccak_pkg;

  localparam int LANES = 25;

  typedef enum logic [2:0] {
    SEQ_LOAD   = 3'b001,
    SEQ_RUN    = 3'b010,
    SEQ_UNLOAD = 3'b100
  } seq_state_e;

  function automatic int share_width(input int shares);
    return (shares > 1) ? $clog2(shares) : 1;
  endfunction

endpackage

// File: rtl/keccak_beat_counter.sv
// Lane/share beat counter shared by the load and unload phases.
// The lane index wraps at 24 and carries into the share index; last flags the final beat.
module keccak_beat_counter
  import keccak_pkg::*;
#(
  parameter  int SHARES = 2,
  localparam int SW     = share_width(SHARES)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          inc,
  input  logic          clr,
  output logic [4:0]    lane_cnt,
  output logic [SW-1:0] share_cnt,
  output logic          last
);

  localparam logic [4:0]    LANE_MAX  = 5'(LANES - 1);
  localparam logic [SW-1:0] SHARE_MAX = SW'(SHARES - 1);

  logic [4:0]    lane_cnt_r;
  logic [SW-1:0] share_cnt_r;
  logic [4:0]    lane_nxt_s;
  logic [SW-1:0] share_nxt_s;
  logic          last_s;

  assign last_s = (lane_cnt_r == LANE_MAX) && (share_cnt_r == SHARE_MAX);

  // Next-count logic: the final beat wraps both counters back to zero.
  always_comb begin
    lane_nxt_s  = lane_cnt_r;
    share_nxt_s = share_cnt_r;
    if (clr) begin
      lane_nxt_s  = 5'd0;
      share_nxt_s = '0;
    end else if (inc) begin
      if (lane_cnt_r == LANE_MAX) begin
        lane_nxt_s = 5'd0;
        if (share_cnt_r == SHARE_MAX) begin
          share_nxt_s = '0;
        end else begin
          share_nxt_s = share_cnt_r + SW'(1);
        end
      end else begin
        lane_nxt_s  = lane_cnt_r + 5'd1;
        share_nxt_s = share_cnt_r;
      end
    end else begin
      lane_nxt_s  = lane_cnt_r;
      share_nxt_s = share_cnt_r;
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      lane_cnt_r  <= 5'd0;
      share_cnt_r <= '0;
    end else begin
      lane_cnt_r  <= lane_nxt_s;
      share_cnt_r <= share_nxt_s;
    end
  end

  assign lane_cnt  = lane_cnt_r;
  assign share_cnt = share_cnt_r;
  assign last      = last_s;

endmodule

// File: rtl/keccak_share_sequencer.sv
// Host-side sequencer: streams shares into the masked datapath, runs the round
// controller, then streams the permuted shares back out in the same order.
module keccak_share_sequencer
  import keccak_pkg::*;
#(
  parameter  int W      = 8,
  parameter  int SHARES = 2,
  localparam int SW     = share_width(SHARES)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          InValid,
  output logic          InReady,
  input  logic [W-1:0]  InData,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [W-1:0]  OutData,
  output logic          LoadEn,
  output logic [W-1:0]  StateDataO,
  input  logic [W-1:0]  StateDataI,
  output logic [4:0]    LaneSel,
  output logic [SW-1:0] ShareSel,
  output logic          CoreReset,
  input  logic          CoreReady,
  output logic          Busy
);

  seq_state_e    state_r;
  seq_state_e    state_nxt_s;
  logic          in_ready_s;
  logic          out_valid_s;
  logic          core_reset_s;
  logic          busy_s;
  logic          inc_s;
  logic          clr_s;
  logic          last_s;
  logic [4:0]    lane_cnt_s;
  logic [SW-1:0] share_cnt_s;

  keccak_beat_counter #(
    .SHARES (SHARES)
  ) u_beat_counter (
    .Clock     (Clock),
    .Reset     (Reset),
    .inc       (inc_s),
    .clr       (clr_s),
    .lane_cnt  (lane_cnt_s),
    .share_cnt (share_cnt_s),
    .last      (last_s)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r <= SEQ_LOAD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and raw output decode; CoreReady only counts while in RUN.
  always_comb begin
    state_nxt_s  = state_r;
    in_ready_s   = 1'b0;
    out_valid_s  = 1'b0;
    core_reset_s = 1'b1;
    busy_s       = 1'b0;
    inc_s        = 1'b0;
    clr_s        = 1'b0;
    case (state_r)
      SEQ_LOAD: begin
        in_ready_s   = 1'b1;
        core_reset_s = 1'b1;
        inc_s        = InValid;
        if (InValid && last_s) begin
          state_nxt_s = SEQ_RUN;
        end else begin
          state_nxt_s = SEQ_LOAD;
        end
      end
      SEQ_RUN: begin
        core_reset_s = 1'b0;
        busy_s       = 1'b1;
        if (CoreReady) begin
          state_nxt_s = SEQ_UNLOAD;
        end else begin
          state_nxt_s = SEQ_RUN;
        end
      end
      SEQ_UNLOAD: begin
        core_reset_s = 1'b0;
        busy_s       = 1'b1;
        out_valid_s  = 1'b1;
        inc_s        = OutReady;
        if (OutReady && last_s) begin
          state_nxt_s = SEQ_LOAD;
        end else begin
          state_nxt_s = SEQ_UNLOAD;
        end
      end
      default: begin
        state_nxt_s = SEQ_LOAD;
        clr_s       = 1'b1;
      end
    endcase
  end

  // Reset low forces the handshake outputs idle and holds the controller in reset.
  assign InReady    = Reset & in_ready_s;
  assign OutValid   = Reset & out_valid_s;
  assign LoadEn     = Reset & in_ready_s & InValid;
  assign CoreReset  = ~Reset | core_reset_s;
  assign Busy       = Reset & busy_s;

  assign StateDataO = InData;
  assign OutData    = StateDataI;
  assign LaneSel    = lane_cnt_s;
  assign ShareSel   = share_cnt_s;

endmodule

// File: tb/tb_keccak_share_sequencer.sv
// Directed-plus-random bench for keccak_share_sequencer with a behavioural
// datapath memory and a beat-index reference model.
module tb_keccak_share_sequencer;

  localparam int W      = 8;
  localparam int SHARES = 2;
  localparam int SW     = 1;
  localparam int NB     = SHARES * 25;
  localparam int GUARD  = 2000;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          InValid;
  logic          InReady;
  logic [W-1:0]  InData;
  logic          OutValid;
  logic          OutReady;
  logic [W-1:0]  OutData;
  logic          LoadEn;
  logic [W-1:0]  StateDataO;
  logic [W-1:0]  StateDataI;
  logic [4:0]    LaneSel;
  logic [SW-1:0] ShareSel;
  logic          CoreReset;
  logic          CoreReady;
  logic          Busy;

  int checks = 0;
  int errors = 0;
  int loaden_cnt = 0;
  int exp_loaden = 0;

  logic [W-1:0] mem [0:SHARES-1][0:24];
  logic [W-1:0] exp_data [0:NB-1];

  keccak_share_sequencer #(.W(W), .SHARES(SHARES)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .InValid    (InValid),
    .InReady    (InReady),
    .InData     (InData),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutData    (OutData),
    .LoadEn     (LoadEn),
    .StateDataO (StateDataO),
    .StateDataI (StateDataI),
    .LaneSel    (LaneSel),
    .ShareSel   (ShareSel),
    .CoreReset  (CoreReset),
    .CoreReady  (CoreReady),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  // Behavioural masked datapath: a lane store addressed by the sequencer selects.
  always @(posedge Clock) begin
    if (LoadEn) begin
      mem[ShareSel][LaneSel] <= StateDataO;
      loaden_cnt <= loaden_cnt + 1;
    end
  end
  assign StateDataI = mem[ShareSel][LaneSel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_idle_load(input string tag);
    chk({tag, "_inready"}, 32'(InReady), 32'd1);
    chk({tag, "_corerst"}, 32'(CoreReset), 32'd1);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_outvalid"}, 32'(OutValid), 32'd0);
    chk({tag, "_lane"}, 32'(LaneSel), 32'd0);
    chk({tag, "_share"}, 32'(ShareSel), 32'd0);
  endtask

  // Feed nbeats accepted input beats; rnd inserts idle cycles at random.
  task automatic do_load(input bit rnd, input int nbeats);
    int k = 0;
    int guard = 0;
    while (k < nbeats && guard < GUARD) begin
      InValid   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      InData    = W'($urandom);
      CoreReady = 1'($urandom_range(0, 1));
      OutReady  = 1'($urandom_range(0, 1));
      #3;
      chk("load_inready", 32'(InReady), 32'd1);
      chk("load_loaden", 32'(LoadEn), 32'(InValid));
      chk("load_lane", 32'(LaneSel), 32'(k % 25));
      chk("load_share", 32'(ShareSel), 32'(k / 25));
      chk("load_datao", 32'(StateDataO), 32'(InData));
      chk("load_corerst", 32'(CoreReset), 32'd1);
      chk("load_busy", 32'(Busy), 32'd0);
      chk("load_outvalid", 32'(OutValid), 32'd0);
      if (InValid) begin
        exp_data[k] = InData;
        k++;
        exp_loaden++;
      end
      tick();
      guard++;
    end
    chk("load_bound", 32'(guard < GUARD), 32'd1);
    chk("load_pulses", 32'(loaden_cnt), 32'(exp_loaden));
  endtask

  // Hold the controller busy for a few cycles, then pulse Ready once.
  task automatic do_run(input int wait_cycles);
    for (int i = 0; i <= wait_cycles; i++) begin
      InValid   = 1'b1;
      OutReady  = 1'b1;
      CoreReady = (i == wait_cycles);
      #3;
      chk("run_busy", 32'(Busy), 32'd1);
      chk("run_corerst", 32'(CoreReset), 32'd0);
      chk("run_inready", 32'(InReady), 32'd0);
      chk("run_loaden", 32'(LoadEn), 32'd0);
      chk("run_outvalid", 32'(OutValid), 32'd0);
      tick();
    end
    CoreReady = 1'b0;
  endtask

  // Drain nbeats output beats; optional five-cycle stall before the first.
  task automatic do_unload(input bit rnd, input bit stall, input int nbeats);
    int k = 0;
    int guard = 0;
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        OutReady = 1'b0;
        #3;
        chk("stall_outvalid", 32'(OutValid), 32'd1);
        chk("stall_lane", 32'(LaneSel), 32'd0);
        chk("stall_data", 32'(OutData), 32'(exp_data[0]));
        tick();
      end
    end
    while (k < nbeats && guard < GUARD) begin
      OutReady  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      InValid   = 1'($urandom_range(0, 1));
      CoreReady = 1'($urandom_range(0, 1));
      #3;
      chk("unl_outvalid", 32'(OutValid), 32'd1);
      chk("unl_busy", 32'(Busy), 32'd1);
      chk("unl_corerst", 32'(CoreReset), 32'd0);
      chk("unl_inready", 32'(InReady), 32'd0);
      chk("unl_loaden", 32'(LoadEn), 32'd0);
      chk("unl_lane", 32'(LaneSel), 32'(k % 25));
      chk("unl_share", 32'(ShareSel), 32'(k / 25));
      chk("unl_data", 32'(OutData), 32'(exp_data[k]));
      if (OutReady) begin
        k++;
      end
      tick();
      guard++;
    end
    chk("unl_bound", 32'(guard < GUARD), 32'd1);
    CoreReady = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    Reset    = 1'b0;
    InValid  = 1'b1;
    OutReady = 1'b1;
    #3;
    chk({tag, "_rst_inready"}, 32'(InReady), 32'd0);
    chk({tag, "_rst_loaden"}, 32'(LoadEn), 32'd0);
    chk({tag, "_rst_outvalid"}, 32'(OutValid), 32'd0);
    chk({tag, "_rst_corerst"}, 32'(CoreReset), 32'd1);
    chk({tag, "_rst_busy"}, 32'(Busy), 32'd0);
    tick();
    Reset   = 1'b1;
    InValid = 1'b0;
    #3;
    chk_idle_load({tag, "_after"});
    tick();
    chk({tag, "_no_stray"}, 32'(loaden_cnt), 32'(exp_loaden));
  endtask

  initial begin
    Reset     = 1'b0;
    InValid   = 1'b1;
    InData    = '0;
    OutReady  = 1'b0;
    CoreReady = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("por_inready", 32'(InReady), 32'd0);
      chk("por_loaden", 32'(LoadEn), 32'd0);
      chk("por_corerst", 32'(CoreReset), 32'd1);
      chk("por_outvalid", 32'(OutValid), 32'd0);
      tick();
    end
    Reset   = 1'b1;
    InValid = 1'b0;
    #3;
    chk_idle_load("por");
    tick();

    // Back-to-back load, stalled unload.
    do_load(1'b0, NB);
    do_run(0);
    do_unload(1'b0, 1'b1, NB);
    InValid = 1'b0;
    #3;
    chk_idle_load("done1");
    tick();

    // Gappy load, randomized unload backpressure.
    do_load(1'b1, NB);
    do_run($urandom_range(1, 6));
    do_unload(1'b1, 1'b0, NB);
    InValid = 1'b0;
    #3;
    chk_idle_load("done2");
    tick();

    // Abort part-way through loading.
    do_load(1'b1, 30);
    pulse_reset("abort_load");

    // Abort part-way through unloading.
    do_load(1'b0, NB);
    do_run(2);
    do_unload(1'b1, 1'b0, 10);
    pulse_reset("abort_unload");

    // Full recovery transaction.
    do_load(1'b1, NB);
    do_run($urandom_range(0, 3));
    do_unload(1'b1, 1'b1, NB);
    InValid = 1'b0;
    #3;
    chk_idle_load("done3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
